// File: rtl/ps2_key_pkg.sv
// Shared constants and FSM state encoding for the PS/2 key controller.
// Optional E0 (extended key) support is enabled by defining PS2_KEY_EXT_KEY_EN.
package ps2_key_pkg;

    localparam logic [7:0] BRK_CODE = 8'hF0;
    localparam logic [7:0] EXT_CODE = 8'hE0;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_POP  = 2'd1,
        S_GAP  = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/ps2_byte_fetch.sv
// FIFO pop handshake: latch the head byte, strobe nextdata_n low for one cycle,
// then wait POP_GAP cycles before looking at ps2_ready again.
module ps2_byte_fetch
    import ps2_key_pkg::*;
#(
    parameter int POP_GAP = 1
) (
    input  logic       clk,
    input  logic       clrn,
    input  logic [7:0] ps2_data,
    input  logic       ps2_ready,
    output logic       nextdata_n,
    output logic [7:0] byte_r,
    output logic       byte_stb
);

    localparam int GAP_W = (POP_GAP < 2) ? 1 : $clog2(POP_GAP + 1);

    fetch_state_t     r_state;
    fetch_state_t     w_state_next;
    logic [GAP_W-1:0] r_gap_cnt;
    logic             w_gap_last;

    assign w_gap_last = (r_gap_cnt == GAP_W'(POP_GAP - 1));

    always_ff @(posedge clk) begin
        if (!clrn) begin
            r_state   <= S_IDLE;
            r_gap_cnt <= '0;
            byte_r    <= 8'h00;
        end else begin
            r_state <= w_state_next;
            if (r_state == S_IDLE && ps2_ready)
                byte_r <= ps2_data;
            // Counter only runs while in S_GAP so every gap starts from zero.
            if (r_state == S_GAP)
                r_gap_cnt <= r_gap_cnt + GAP_W'(1);
            else
                r_gap_cnt <= '0;
        end
    end

    always_comb begin
        w_state_next = r_state;
        nextdata_n   = 1'b1;
        byte_stb     = 1'b0;
        case (r_state)
            S_IDLE: if (ps2_ready) w_state_next = S_POP;
            S_POP: begin
                nextdata_n   = 1'b0;
                byte_stb     = 1'b1;
                w_state_next = S_GAP;
            end
            S_GAP:   if (w_gap_last) w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

endmodule

// File: rtl/ps2_key_ctrl.sv
// PS/2 scan-byte decoder: tracks the currently held key, counts distinct presses.
// Define PS2_KEY_EXT_KEY_EN to track E0-prefixed keys separately (key_ext live).
module ps2_key_ctrl
    import ps2_key_pkg::*;
#(
    parameter int CNT_W   = 8,
    parameter int POP_GAP = 1
) (
    input  logic             clk,
    input  logic             clrn,
    input  logic [7:0]       ps2_data,
    input  logic             ps2_ready,
    input  logic             ps2_overflow,
    output logic             nextdata_n,
    output logic             key_valid,
    output logic [7:0]       key_code,
    output logic             key_ext,
    output logic [CNT_W-1:0] press_cnt,
    output logic             ovf_flag
);

    logic [7:0]       w_byte;
    logic             w_byte_stb;
    logic             w_same_key;
    logic             r_brk_pend;
    logic             r_key_valid;
    logic [7:0]       r_key_code;
    logic [CNT_W-1:0] r_press_cnt;
    logic             r_ovf;

    ps2_byte_fetch #(
        .POP_GAP (POP_GAP)
    ) u_fetch (
        .clk        (clk),
        .clrn       (clrn),
        .ps2_data   (ps2_data),
        .ps2_ready  (ps2_ready),
        .nextdata_n (nextdata_n),
        .byte_r     (w_byte),
        .byte_stb   (w_byte_stb)
    );

`ifdef PS2_KEY_EXT_KEY_EN
    logic r_ext_pend;
    logic r_key_ext;

    assign w_same_key = r_key_valid && (w_byte == r_key_code) && (r_ext_pend == r_key_ext);
    assign key_ext    = r_key_ext;
`else
    assign w_same_key = r_key_valid && (w_byte == r_key_code);
    assign key_ext    = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!clrn) begin
            r_brk_pend  <= 1'b0;
            r_key_valid <= 1'b0;
            r_key_code  <= 8'h00;
            r_press_cnt <= '0;
            r_ovf       <= 1'b0;
`ifdef PS2_KEY_EXT_KEY_EN
            r_ext_pend  <= 1'b0;
            r_key_ext   <= 1'b0;
`endif
        end else begin
            if (ps2_overflow)
                r_ovf <= 1'b1;
            if (w_byte_stb) begin
                if (w_byte == BRK_CODE) begin
                    r_brk_pend <= 1'b1;
                end else if (w_byte == EXT_CODE) begin
`ifdef PS2_KEY_EXT_KEY_EN
                    r_ext_pend <= 1'b1;
`endif
                end else begin
                    r_brk_pend <= 1'b0;
`ifdef PS2_KEY_EXT_KEY_EN
                    r_ext_pend <= 1'b0;
`endif
                    // Releases of keys other than the held one are dropped.
                    if (r_brk_pend) begin
                        if (w_same_key)
                            r_key_valid <= 1'b0;
                    end else if (!w_same_key) begin
                        r_key_valid <= 1'b1;
                        r_key_code  <= w_byte;
                        r_press_cnt <= r_press_cnt + CNT_W'(1);
`ifdef PS2_KEY_EXT_KEY_EN
                        r_key_ext   <= r_ext_pend;
`endif
                    end
                end
            end
        end
    end

    assign key_valid = r_key_valid;
    assign key_code  = r_key_code;
    assign press_cnt = r_press_cnt;
    assign ovf_flag  = r_ovf;

endmodule

// File: tb/tb_ps2_key_ctrl.sv
// Self-checking bench for ps2_key_ctrl: directed scenarios plus a random byte stream
// checked against a key-state reference model.
module tb_ps2_key_ctrl;

    localparam int CNT_W   = 8;
    localparam int POP_GAP = 1;
`ifdef PS2_KEY_EXT_KEY_EN
    localparam bit EXT_EN = 1'b1;
`else
    localparam bit EXT_EN = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             clrn = 1'b0;
    logic [7:0]       ps2_data = 8'h00;
    logic             ps2_ready = 1'b0;
    logic             ps2_overflow = 1'b0;
    logic             nextdata_n;
    logic             key_valid;
    logic [7:0]       key_code;
    logic             key_ext;
    logic [CNT_W-1:0] press_cnt;
    logic             ovf_flag;

    int vectors = 0;
    int miscompares = 0;
    int pulses = 0;

    // Reference model: held key identity is {ext, code}; prefixes are pending bits.
    bit       m_held;
    bit [8:0] m_id;
    bit       m_brk;
    bit       m_ext;
    int       m_cnt;

    ps2_key_ctrl #(
        .CNT_W   (CNT_W),
        .POP_GAP (POP_GAP)
    ) u_dut (
        .clk          (clk),
        .clrn         (clrn),
        .ps2_data     (ps2_data),
        .ps2_ready    (ps2_ready),
        .ps2_overflow (ps2_overflow),
        .nextdata_n   (nextdata_n),
        .key_valid    (key_valid),
        .key_code     (key_code),
        .key_ext      (key_ext),
        .press_cnt    (press_cnt),
        .ovf_flag     (ovf_flag)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (nextdata_n === 1'b0) pulses++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_held = 0; m_id = '0; m_brk = 0; m_ext = 0; m_cnt = 0;
    endtask

    task automatic model_byte(input bit [7:0] b);
        bit [8:0] id;
        if (b == 8'hF0) m_brk = 1;
        else if (b == 8'hE0) begin
            if (EXT_EN) m_ext = 1;
        end else begin
            id = {m_ext & EXT_EN, b};
            if (m_brk) begin
                if (m_held && m_id == id) m_held = 0;
            end else if (!(m_held && m_id == id)) begin
                m_held = 1;
                m_id   = id;
                m_cnt  = (m_cnt + 1) % (1 << CNT_W);
            end
            m_brk = 0;
            m_ext = 0;
        end
    endtask

    task automatic compare_model(input string tag);
        chk({tag, ".valid"}, 32'(key_valid), 32'(m_held));
        chk({tag, ".code"},  32'(key_code),  32'(m_id[7:0]));
        chk({tag, ".ext"},   32'(key_ext),   32'(m_id[8]));
        chk({tag, ".cnt"},   32'(press_cnt), 32'(m_cnt));
    endtask

    task automatic do_reset();
        clrn = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        clrn = 1'b1;
        model_reset();
    endtask

    // Present one byte, wait for its pop, then check pulse width and decoded outputs.
    task automatic send_byte(input bit [7:0] b, input bit with_ovf, input bit check);
        bit got;
        got = 0;
        ps2_data = b;
        ps2_ready = 1'b1;
        ps2_overflow = with_ovf;
        for (int i = 0; i < 20 && !got; i++) begin
            @(posedge clk);
            #1;
            ps2_overflow = 1'b0;
            if (nextdata_n === 1'b0) got = 1;
        end
        chk("pop_seen", 32'(got), 32'd1);
        ps2_ready = 1'b0;
        @(posedge clk);
        #1;
        chk("pop_width", 32'(nextdata_n), 32'd1);
        model_byte(b);
        if (check) compare_model($sformatf("byte_%02h", b));
        repeat (POP_GAP) @(posedge clk);
        #1;
    endtask

    initial begin
        int p0;
        bit [7:0] b;
        int r;

        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst.nextdata_n", 32'(nextdata_n), 32'd1);
        chk("rst.ovf", 32'(ovf_flag), 32'd0);
        compare_model("rst");
        clrn = 1'b1;

        // Overflow pulse concurrent with a byte that must still decode
        send_byte(8'h1C, 1'b0, 1'b1);
        send_byte(8'h32, 1'b1, 1'b1);
        chk("ovf.set", 32'(ovf_flag), 32'd1);
        send_byte(8'h4D, 1'b0, 1'b1);
        chk("ovf.held", 32'(ovf_flag), 32'd1);

        // Reset asserted while nextdata_n is low
        ps2_data = 8'h2B;
        ps2_ready = 1'b1;
        for (int i = 0; i < 20 && nextdata_n !== 1'b0; i++) begin
            @(posedge clk);
            #1;
        end
        chk("midpop.low", 32'(nextdata_n), 32'd0);
        clrn = 1'b0;
        ps2_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        clrn = 1'b1;
        model_reset();
        chk("midpop.nextdata_n", 32'(nextdata_n), 32'd1);
        chk("midpop.ovf", 32'(ovf_flag), 32'd0);
        compare_model("midpop");
        repeat (3) @(posedge clk);
        #1;
        chk("midpop.idle", 32'(nextdata_n), 32'd1);

        // Repeats and release: 1C 1C 1C F0 1C
        p0 = pulses;
        send_byte(8'h1C, 1'b0, 1'b1);
        chk("t2.code", 32'(key_code), 32'h1C);
        send_byte(8'h1C, 1'b0, 1'b1);
        send_byte(8'h1C, 1'b0, 1'b1);
        chk("t2.cnt", 32'(press_cnt), 32'd1);
        send_byte(8'hF0, 1'b0, 1'b1);
        send_byte(8'h1C, 1'b0, 1'b1);
        chk("t2.released", 32'(key_valid), 32'd0);
        chk("t2.pulses", 32'(pulses - p0), 32'd5);

        // Last-key-wins: 1C 32 F0 1C F0 32
        do_reset();
        send_byte(8'h1C, 1'b0, 1'b1);
        send_byte(8'h32, 1'b0, 1'b1);
        chk("t3.code", 32'(key_code), 32'h32);
        chk("t3.cnt", 32'(press_cnt), 32'd2);
        send_byte(8'hF0, 1'b0, 1'b1);
        send_byte(8'h1C, 1'b0, 1'b1);
        chk("t3.still_held", 32'(key_valid), 32'd1);
        send_byte(8'hF0, 1'b0, 1'b1);
        send_byte(8'h32, 1'b0, 1'b1);
        chk("t3.released", 32'(key_valid), 32'd0);

        // Extended key: E0 75, F0 75, E0 F0 75
        do_reset();
        send_byte(8'hE0, 1'b0, 1'b1);
        send_byte(8'h75, 1'b0, 1'b1);
        chk("t4.ext", 32'(key_ext), 32'(EXT_EN));
        chk("t4.code", 32'(key_code), 32'h75);
        send_byte(8'hF0, 1'b0, 1'b1);
        send_byte(8'h75, 1'b0, 1'b1);
        chk("t4.plain_rel", 32'(key_valid), EXT_EN ? 32'd1 : 32'd0);
        send_byte(8'hE0, 1'b0, 1'b1);
        send_byte(8'hF0, 1'b0, 1'b1);
        send_byte(8'h75, 1'b0, 1'b1);
        chk("t4.ext_rel", 32'(key_valid), 32'd0);

        // Counter wrap: 256 alternating presses
        do_reset();
        for (int i = 0; i < 256; i++) begin
            send_byte((i % 2 == 0) ? 8'h1C : 8'h32, 1'b0, 1'b0);
            if (i == 254) chk("t5.cnt_ff", 32'(press_cnt), 32'hFF);
        end
        chk("t5.cnt_wrap", 32'(press_cnt), 32'd0);
        chk("t5.code", 32'(key_code), 32'h32);
        compare_model("t5");

        // Random stream over a small key alphabet with prefixes
        do_reset();
        for (int i = 0; i < 300; i++) begin
            r = int'($urandom_range(0, 9));
            case (r)
                0, 1:    b = 8'hF0;
                2:       b = 8'hE0;
                3, 4, 5: b = 8'h1C;
                6, 7:    b = 8'h32;
                8:       b = 8'h75;
                default: b = 8'($urandom);
            endcase
            send_byte(b, 1'b0, 1'b1);
        end
        chk("rand.ovf", 32'(ovf_flag), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
